// File: rtl/mem_req_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_req_pkg : shared types and defaults for the memory request port   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package mem_req_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

  function automatic int entry_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_req_fifo : synchronous FIFO, power-of-two depth, async reset      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module mem_req_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             PW         = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_req_port : per-core buffered request port to shared memory.       |
// |   Optional: MEM_REQ_TIMEOUT_EN enables the processor_resp timeout.    |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module mem_req_port
  import mem_req_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic                        cpu_req_write,
  input  logic [ADDR_WIDTH-1:0]       cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]       cpu_req_wdata,
  output logic                        cpu_rsp_valid,
  input  logic                        cpu_rsp_ready,
  output logic [DATA_WIDTH-1:0]       cpu_rsp_rdata,
  output logic                        cpu_rsp_err,
  output logic                        processor_req,
  output logic                        mem_read_req,
  output logic                        mem_write_req,
  output logic [ADDR_WIDTH-1:0]       addr,
  output logic [DATA_WIDTH-1:0]       mem_write_data,
  input  logic [DATA_WIDTH-1:0]       mem_read_data,
  input  logic                        processor_resp,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t                push_entry, head_entry;
  logic                  fifo_full, fifo_empty, pop;
  state_e                state_q;
  logic                  processor_req_q, mem_read_req_q, mem_write_req_q;
  logic                  rsp_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

  assign push_entry = {cpu_req_write, cpu_req_addr, cpu_req_wdata};
  assign pop        = (state_q == IDLE) && !fifo_empty;

  assign cpu_req_ready  = !fifo_full;
  assign cpu_rsp_valid  = rsp_valid_q;
  assign cpu_rsp_rdata  = rdata_q;
  assign processor_req  = processor_req_q;
  assign mem_read_req   = mem_read_req_q;
  assign mem_write_req  = mem_write_req_q;
  assign addr           = addr_q;
  assign mem_write_data = wdata_q;

  mem_req_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cpu_req_valid),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q;
  logic          rsp_err_q;
  assign cpu_rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign cpu_rsp_err    = 1'b0;
`endif

  // The registered mem_write_req_q doubles as the load/store flag of the held request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      processor_req_q <= 1'b0;
      mem_read_req_q  <= 1'b0;
      mem_write_req_q <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rdata_q         <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      tmo_q           <= '0;
      rsp_err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            processor_req_q <= 1'b1;
            mem_read_req_q  <= !head_entry.write;
            mem_write_req_q <= head_entry.write;
            addr_q          <= head_entry.addr;
            wdata_q         <= head_entry.wdata;
            state_q         <= ISSUE;
`ifdef MEM_REQ_TIMEOUT_EN
            tmo_q           <= '0;
`endif
          end
        end
        ISSUE: begin
          if (processor_resp) begin
            processor_req_q <= 1'b0;
            mem_read_req_q  <= 1'b0;
            mem_write_req_q <= 1'b0;
            rdata_q         <= mem_write_req_q ? '0 : mem_read_data;
            rsp_valid_q     <= 1'b1;
            state_q         <= RESP;
`ifdef MEM_REQ_TIMEOUT_EN
            rsp_err_q       <= 1'b0;
          end else if (tmo_q == TMO_LAST) begin
            processor_req_q <= 1'b0;
            mem_read_req_q  <= 1'b0;
            mem_write_req_q <= 1'b0;
            rdata_q         <= '0;
            rsp_valid_q     <= 1'b1;
            rsp_err_q       <= 1'b1;
            state_q         <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (cpu_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_req_port : randomized bench with transaction-level reference   |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_mem_req_port;

  localparam int DW    = 16;
  localparam int AW    = 14;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req_valid = 1'b0, cpu_req_write = 1'b0;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [DW-1:0] cpu_req_wdata = '0;
  logic          cpu_rsp_ready = 1'b0;
  logic [DW-1:0] mem_read_data = '0;
  logic          processor_resp = 1'b0;
  logic          cpu_req_ready, cpu_rsp_valid, cpu_rsp_err;
  logic [DW-1:0] cpu_rsp_rdata, mem_write_data;
  logic          processor_req, mem_read_req, mem_write_req;
  logic [AW-1:0] addr;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  mem_req_port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .processor_req(processor_req), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .addr(addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .processor_resp(processor_resp), .fifo_count(fifo_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of accepted requests plus the one in flight, timed by edge numbers.
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } mreq_t;

  mreq_t         mq[$];
  mreq_t         cur;
  bit            m_busy, m_wait, m_rspv, m_err;
  logic [DW-1:0] m_rdata;
  int            edge_no, free_at, issue_edge;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_busy = 0; m_wait = 0; m_rspv = 0; m_err = 0; m_rdata = '0;
        free_at = 0;
      end else begin
        int cnt;
        edge_no++;
        cnt = mq.size();
        if (!m_busy) begin
          if (edge_no >= free_at && cnt > 0) begin
            cur = mq.pop_front();
            m_busy = 1; m_wait = 1; issue_edge = edge_no;
          end
        end else if (m_wait) begin
          if (processor_resp) begin
            m_wait = 0; m_rspv = 1; m_err = 0;
            m_rdata = cur.w ? '0 : mem_read_data;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (edge_no - issue_edge >= TMO) begin
            m_wait = 0; m_rspv = 1; m_err = 1; m_rdata = '0;
          end
`endif
        end else if (m_rspv && cpu_rsp_ready) begin
          m_rspv = 0; m_busy = 0;
          free_at = edge_no + 2;
        end
        if (cpu_req_valid && cnt < DEPTH) begin
          mreq_t r;
          r.w = cpu_req_write; r.a = cpu_req_addr; r.d = cpu_req_wdata;
          mq.push_back(r);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        bit ereq;
        ereq = m_busy && m_wait;
        check("processor_req", processor_req, ereq);
        check("mem_read_req", mem_read_req, ereq && !cur.w);
        check("mem_write_req", mem_write_req, ereq && cur.w);
        if (ereq) check("addr", addr, cur.a);
        if (ereq && cur.w) check("mem_write_data", mem_write_data, cur.d);
        check("cpu_rsp_valid", cpu_rsp_valid, m_rspv);
        if (m_rspv) begin
          check("cpu_rsp_rdata", cpu_rsp_rdata, m_rdata);
          check("cpu_rsp_err", cpu_rsp_err, m_err);
        end
        check("fifo_count", fifo_count, mq.size());
        check("cpu_req_ready", cpu_req_ready, mq.size() < DEPTH);
      end
    end
  end

  bit auto_mem = 0;
  bit auto_rsp = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        processor_resp = ($urandom_range(0, 2) == 0);
        mem_read_data  = DW'($urandom);
      end
      if (auto_rsp) cpu_rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit r;
    bit done = 0;
    cpu_req_valid = 1'b1; cpu_req_write = w; cpu_req_addr = a; cpu_req_wdata = d;
    for (int i = 0; i < 200 && !done; i++) begin
      r = cpu_req_ready;
      step();
      if (r) done = 1;
    end
    cpu_req_valid = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL push_accept: got no acceptance, expected acceptance within 200 cycles");
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!processor_req && !cpu_rsp_valid && fifo_count == 0) ok = 1;
      else step();
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain: got busy port, expected idle within 300 cycles");
    end
    repeat (2) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, cpu_req_ready, 1'b1);
    check({tag, "_rsp_valid"}, cpu_rsp_valid, 1'b0);
    check({tag, "_rsp_rdata"}, cpu_rsp_rdata, '0);
    check({tag, "_rsp_err"}, cpu_rsp_err, 1'b0);
    check({tag, "_processor_req"}, processor_req, 1'b0);
    check({tag, "_read_req"}, mem_read_req, 1'b0);
    check({tag, "_write_req"}, mem_write_req, 1'b0);
    check({tag, "_addr"}, addr, '0);
    check({tag, "_wdata"}, mem_write_data, '0);
    check({tag, "_count"}, fifo_count, '0);
  endtask

  initial begin
    repeat (2) step();
    check_reset_values("rst");
    reset = 1'b0;
    step();

    // Single load, memory answers two cycles into ISSUE.
    push(1'b0, 14'h0005, 16'h0000);
    check("ld_count_after_push", fifo_count, 1);
    check("ld_no_early_req", processor_req, 1'b0);
    step();
    check("ld_req", processor_req, 1'b1);
    check("ld_read_req", mem_read_req, 1'b1);
    check("ld_addr", addr, 14'h0005);
    step();
    check("ld_addr_hold", addr, 14'h0005);
    processor_resp = 1'b1; mem_read_data = 16'h0006;
    step();
    processor_resp = 1'b0;
    check("ld_rsp_valid", cpu_rsp_valid, 1'b1);
    check("ld_rsp_rdata", cpu_rsp_rdata, 16'h0006);
    check("ld_rsp_err", cpu_rsp_err, 1'b0);
    check("ld_req_dropped", processor_req, 1'b0);
    step();
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
    check("ld_rsp_done", cpu_rsp_valid, 1'b0);
    repeat (2) step();

    // Store then load to the same address.
    push(1'b1, 14'h0010, 16'hBEEF);
    push(1'b0, 14'h0010, 16'h0000);
    check("st_write_req", mem_write_req, 1'b1);
    check("st_read_req", mem_read_req, 1'b0);
    check("st_wdata", mem_write_data, 16'hBEEF);
    check("st_addr", addr, 14'h0010);
    check("st_count", fifo_count, 1);
    processor_resp = 1'b1; mem_read_data = 16'h5555;
    step();
    processor_resp = 1'b0;
    check("st_rsp_valid", cpu_rsp_valid, 1'b1);
    check("st_rsp_rdata_zero", cpu_rsp_rdata, 16'h0000);
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
    check("release_no_req", processor_req, 1'b0);
    step();
    check("idle_no_req", processor_req, 1'b0);
    step();
    check("ld2_req", mem_read_req, 1'b1);
    check("ld2_addr", addr, 14'h0010);
    processor_resp = 1'b1; mem_read_data = 16'h1234;
    step();
    processor_resp = 1'b0;

    // Response stall with a request waiting behind it.
    push(1'b0, 14'h0022, 16'hAAAA);
    repeat (9) step();
    check("stall_rsp_valid", cpu_rsp_valid, 1'b1);
    check("stall_rsp_rdata", cpu_rsp_rdata, 16'h1234);
    check("stall_no_issue", processor_req, 1'b0);
    check("stall_count", fifo_count, 1);
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
    auto_mem = 1; auto_rsp = 1;
    drain();

    // Back-pressure: five pushes with memory stalled.
    auto_mem = 0; auto_rsp = 0; processor_resp = 1'b0; cpu_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, AW'(14'h0040 + i), 16'h0000);
    check("bp_ready_low", cpu_req_ready, 1'b0);
    check("bp_count_full", fifo_count, 4);
    cpu_req_valid = 1'b1; cpu_req_addr = 14'h0066;
    step();
    check("bp_not_accepted", fifo_count, 4);
    check("bp_head_addr", addr, 14'h0040);
    auto_mem = 1; auto_rsp = 1;
    push(1'b1, 14'h0066, 16'h6666);
    drain();

    // Asynchronous reset while a request is in ISSUE and three are buffered.
    auto_mem = 0; auto_rsp = 0; processor_resp = 1'b0; cpu_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, AW'(14'h0100 + i), DW'(16'hC000 + i));
    check("mid_count", fifo_count, 3);
    check("mid_req", processor_req, 1'b1);
    #3 reset = 1'b1;
    #1 check_reset_values("async");
    repeat (2) step();
    reset = 1'b0;
    processor_resp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_reset_no_rsp", cpu_rsp_valid, 1'b0);
    end
    processor_resp = 1'b0;

`ifdef MEM_REQ_TIMEOUT_EN
    cpu_rsp_ready = 1'b0;
    push(1'b0, 14'h0033, 16'h0000);
    step();
    check("tmo_req", processor_req, 1'b1);
    repeat (7) step();
    check("tmo_still_waiting", cpu_rsp_valid, 1'b0);
    step();
    check("tmo_rsp_valid", cpu_rsp_valid, 1'b1);
    check("tmo_err", cpu_rsp_err, 1'b1);
    check("tmo_rdata", cpu_rsp_rdata, 16'h0000);
    check("tmo_req_dropped", processor_req, 1'b0);
    cpu_rsp_ready = 1'b1;
    step();
`endif

    // Randomized traffic against the reference.
    auto_mem = 1; auto_rsp = 1;
    for (int i = 0; i < 600; i++) begin
      cpu_req_valid = ($urandom_range(0, 1) == 1);
      cpu_req_write = ($urandom_range(0, 1) == 1);
      cpu_req_addr  = AW'($urandom);
      cpu_req_wdata = DW'($urandom);
      step();
    end
    cpu_req_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
